lcd_init_sequencer: RTL and testbench

LCD_INIT_SEQUENCER -- requirements
Module: lcd_init_sequencer

---
 rtl/lcd_init_sequencer.sv | 116 +++++++++++
 tb/tb_lcd_init_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_init_sequencer.sv
// rtl/lcd_init_sequencer.sv - ROM-driven LCD power-up sequencer
// Walks an init ROM of command/data/delay/end words and feeds bytes to an LCD bus writer.
module lcd_init_sequencer #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 16,
    parameter int TICKS_PER_UNIT = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [7:0]            wr_byte,
    output logic                  wr_dc,
    output logic                  busy,
    output logic                  done
);
    // Sized for the largest 14-bit delay count times the tick scale.
    localparam int CNT_W = $clog2(16383 * TICKS_PER_UNIT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_DELAY = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] T_CMD   = 2'd0;
    localparam logic [1:0] T_DATA  = 2'd1;
    localparam logic [1:0] T_DELAY = 2'd2;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_wr_valid;
    logic [7:0]            r_wr_byte;
    logic                  r_wr_dc;

    logic [1:0]            w_type;
    logic                  w_last_addr;
    logic [CNT_W-1:0]      w_delay_ticks;

    assign w_type        = rom_data[15:14];
    assign w_last_addr   = (r_addr == {ADDR_WIDTH{1'b1}});
    assign w_delay_ticks = CNT_W'(rom_data[13:0]) * CNT_W'(TICKS_PER_UNIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_wr_valid <= 1'b0;
            r_wr_byte  <= 8'h00;
            r_wr_dc    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    case (w_type)
                        T_CMD, T_DATA: begin
                            r_wr_byte  <= rom_data[7:0];
                            r_wr_dc    <= w_type[0];
                            r_wr_valid <= 1'b1;
                            r_state    <= S_SEND;
                        end
                        T_DELAY: begin
                            r_cnt   <= w_delay_ticks;
                            r_state <= S_DELAY;
                        end
                        default: r_state <= S_DONE;
                    endcase
                end
                S_SEND: begin
                    if (wr_ready) begin
                        r_wr_valid <= 1'b0;
                        if (w_last_addr) begin
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DELAY: begin
                    // A zero count still leaves here after one cycle.
                    if (r_cnt < CNT_W'(2)) begin
                        r_cnt <= '0;
                        if (w_last_addr) begin
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr = r_addr;
    assign wr_valid = r_wr_valid;
    assign wr_byte  = r_wr_byte;
    assign wr_dc    = r_wr_dc;
    assign busy     = (r_state == S_FETCH) || (r_state == S_SEND) || (r_state == S_DELAY);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// tb/tb_lcd_init_sequencer.sv - directed bench for lcd_init_sequencer
module tb_lcd_init_sequencer;
    localparam int AW  = 7;
    localparam int DW  = 16;
    localparam int TPU = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          wr_ready = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          wr_valid;
    logic [7:0]    wr_byte;
    logic          wr_dc;
    logic          busy;
    logic          done;

    logic [15:0] rom [0:127];
    logic [8:0]  exp_q [$];
    int errors = 0;
    int checks = 0;
    int n_edges;
    int watch_cnt;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    lcd_init_sequencer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TICKS_PER_UNIT(TPU)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_byte (wr_byte),
        .wr_dc   (wr_dc),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every accepted byte is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
                check("byte_unexpected", {23'd0, wr_dc, wr_byte}, 32'h0);
                check("byte_queue_empty", 32'd0, 32'd1);
            end else begin
                check("byte", {23'd0, wr_dc, wr_byte}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 128; i++) rom[i] = w;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Counts edges until done (bounded) and cycles spent busy at watch_addr.
    task automatic run_to_done(input int limit, input logic [AW-1:0] watch,
                               output int n, output int cnt);
        n   = 0;
        cnt = 0;
        while (n < limit) begin
            tick(1);
            n++;
            if (busy && rom_addr == watch) cnt++;
            if (done) break;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        fill_rom(16'hC000);
        #2 rst = 1'b1;
        #1;
        check("rst_addr", {25'd0, rom_addr}, 32'd0);
        check("rst_outs", {20'd0, wr_valid, wr_dc, wr_byte, busy, done}, 32'd0);
        tick(3);
        rst = 1'b0;
        tick(3);
        check("idle_no_start", {30'd0, busy, done}, 32'd0);

        // Command, 2-unit delay, command, end marker.
        rom[0] = 16'h0011; rom[1] = 16'h8002; rom[2] = 16'h0029; rom[3] = 16'hC000;
        wr_ready = 1'b1;
        exp_q.push_back(9'h011);
        exp_q.push_back(9'h029);
        pulse_start();
        check("t1_busy_after_start", {31'd0, busy}, 32'd1);
        run_to_done(100, 7'd1, n_edges, watch_cnt);
        check("t1_edges_to_done", n_edges, 32'd14);
        check("t1_fetch_plus_delay", watch_cnt, 32'd9);
        check("t1_final", {23'd0, rom_addr, busy, done}, {23'd0, 7'd3, 1'b0, 1'b1});
        check("t1_queue_drained", exp_q.size(), 32'd0);

        // Back-pressure: byte held stable while wr_ready is low.
        fill_rom(16'hC000);
        rom[0] = 16'h0036; rom[1] = 16'h4048; rom[2] = 16'hC000;
        wr_ready = 1'b0;
        exp_q.push_back(9'h036);
        exp_q.push_back(9'h148);
        pulse_start();
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold", {22'd0, wr_valid, wr_dc, wr_byte}, {22'd0, 1'b1, 1'b0, 8'h36});
            tick(1);
        end
        wr_ready = 1'b1;
        run_to_done(100, 7'd0, n_edges, watch_cnt);
        check("t2_final_addr", {25'd0, rom_addr}, 32'd2);
        check("t2_queue_drained", exp_q.size(), 32'd0);

        // Zero-length delay.
        fill_rom(16'hC000);
        rom[0] = 16'h8000;
        pulse_start();
        run_to_done(100, 7'd0, n_edges, watch_cnt);
        check("t3_edges_to_done", n_edges, 32'd3);
        check("t3_delay_cycles", watch_cnt, 32'd1);

        // No end marker: stops at the top address instead of wrapping.
        fill_rom(16'h0000);
        for (int i = 0; i < 128; i++) exp_q.push_back(9'h000);
        pulse_start();
        run_to_done(1000, 7'd0, n_edges, watch_cnt);
        check("t4_edges_to_done", n_edges, 32'd256);
        check("t4_final_addr", {25'd0, rom_addr}, 32'd127);
        check("t4_queue_drained", exp_q.size(), 32'd0);
        tick(4);
        check("t4_no_wrap", {24'd0, rom_addr, done}, {24'd0, 7'd127, 1'b1});

        // Reset in the middle of a long delay, then replay.
        fill_rom(16'hC000);
        rom[0] = 16'h0011; rom[1] = 16'h8005; rom[2] = 16'h0022; rom[3] = 16'hC000;
        exp_q.push_back(9'h011);
        pulse_start();
        tick(8);
        check("t5_in_delay", {24'd0, rom_addr, busy}, {24'd0, 7'd1, 1'b1});
        #2 rst = 1'b1;
        #1;
        check("t5_rst_addr", {25'd0, rom_addr}, 32'd0);
        check("t5_rst_outs", {20'd0, wr_valid, wr_dc, wr_byte, busy, done}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("t5_quiet_after_rst", {30'd0, wr_valid, busy}, 32'd0);
        exp_q.push_back(9'h011);
        exp_q.push_back(9'h022);
        pulse_start();
        run_to_done(200, 7'd1, n_edges, watch_cnt);
        check("t5_edges_to_done", n_edges, 32'd26);
        check("t5_final_addr", {25'd0, rom_addr}, 32'd3);
        check("t5_queue_drained", exp_q.size(), 32'd0);

        // start while busy is ignored; start in DONE replays.
        rom[0] = 16'h0011; rom[1] = 16'h8002; rom[2] = 16'h0029; rom[3] = 16'hC000;
        exp_q.push_back(9'h011);
        exp_q.push_back(9'h029);
        pulse_start();
        tick(3);
        check("t6_busy_before_pulse", {31'd0, busy}, 32'd1);
        pulse_start();
        run_to_done(100, 7'd0, n_edges, watch_cnt);
        check("t6_first_final", {24'd0, rom_addr, done}, {24'd0, 7'd3, 1'b1});
        check("t6_first_queue", exp_q.size(), 32'd0);
        exp_q.push_back(9'h011);
        exp_q.push_back(9'h029);
        pulse_start();
        check("t6_restart", {23'd0, rom_addr, busy, done}, {23'd0, 7'd0, 1'b1, 1'b0});
        run_to_done(100, 7'd1, n_edges, watch_cnt);
        check("t6_edges_to_done", n_edges, 32'd14);
        check("t6_queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
